// File: rtl/note_envelope.sv
// ADSR amplitude envelope between the wavetable oscillator and the PWM stage.
// Level steps once per tick; the oscillator sample is scaled by the level around midscale.
module note_envelope #(
    parameter int unsigned TICK_DIV      = 4800,
    parameter int unsigned ATTACK_STEP   = 8,
    parameter int unsigned DECAY_STEP    = 1,
    parameter int unsigned SUSTAIN_LEVEL = 160,
    parameter int unsigned RELEASE_STEP  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sample_in,
    input  logic       trigger,
    input  logic       gate,
    output logic [7:0] sample_out,
    output logic [7:0] env_level,
    output logic       active
);

    localparam int unsigned    CntW         = $clog2(TICK_DIV);
    localparam logic [CntW-1:0] CntMax      = CntW'(TICK_DIV - 1);
    localparam logic [8:0]     AttackStep   = 9'(ATTACK_STEP);
    localparam logic [8:0]     DecayStep    = 9'(DECAY_STEP);
    localparam logic [8:0]     ReleaseStep  = 9'(RELEASE_STEP);
    localparam logic [7:0]     SustainLevel = 8'(SUSTAIN_LEVEL);

    typedef enum logic [2:0] {
        StIdle,
        StAttack,
        StDecay,
        StSustain,
        StRelease
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      level_q, level_d;
    logic [7:0]      sample_out_q, sample_out_d;
    logic            tick;

    logic [8:0]  atk_sum, dec_diff, rel_diff;
    logic [7:0]  atk_lvl, dec_lvl, rel_lvl;
    logic signed [8:0]  smp_s, lvl_s;
    logic signed [17:0] prod, scaled;

    // Tick divider; a trigger realigns it so the first step is a full period away.
    always_comb begin
        tick  = (cnt_q == CntMax);
        cnt_d = cnt_q + CntW'(1);
        if (trigger || tick) begin
            cnt_d = '0;
        end
    end

    // Saturating level arithmetic, 9 bits wide so carry/borrow reveal the clamp.
    always_comb begin
        atk_sum  = {1'b0, level_q} + AttackStep;
        atk_lvl  = atk_sum[8] ? 8'hFF : atk_sum[7:0];
        dec_diff = {1'b0, level_q} - DecayStep;
        dec_lvl  = (dec_diff[8] || (dec_diff[7:0] < SustainLevel)) ? SustainLevel
                                                                    : dec_diff[7:0];
        rel_diff = {1'b0, level_q} - ReleaseStep;
        rel_lvl  = rel_diff[8] ? 8'h00 : rel_diff[7:0];
    end

    // Envelope next-state and level; trigger wins over a coincident tick.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        if (trigger) begin
            state_d = StAttack;
        end else if (tick) begin
            unique case (state_q)
                StIdle: begin
                    level_d = 8'h00;
                end
                StAttack: begin
                    if (!gate) begin
                        state_d = StRelease;
                    end else begin
                        level_d = atk_lvl;
                        if (atk_lvl == 8'hFF) begin
                            state_d = StDecay;
                        end
                    end
                end
                StDecay: begin
                    if (!gate) begin
                        state_d = StRelease;
                    end else begin
                        level_d = dec_lvl;
                        if (dec_lvl == SustainLevel) begin
                            state_d = StSustain;
                        end
                    end
                end
                StSustain: begin
                    if (!gate) begin
                        state_d = StRelease;
                    end
                end
                StRelease: begin
                    // Gate rising again does not resume the note; only trigger does.
                    level_d = rel_lvl;
                    if (rel_lvl == 8'h00) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                    level_d = 8'h00;
                end
            endcase
        end
    end

    // Scale the sample around midscale: 128 + floor((sample-128) * level / 256).
    always_comb begin
        smp_s        = $signed({1'b0, sample_in}) - 9'sd128;
        lvl_s        = $signed({1'b0, level_q});
        prod         = 18'(smp_s) * 18'(lvl_s);
        scaled       = (prod >>> 8) + 18'sd128;
        sample_out_d = scaled[7:0];
    end

    // State, level, divider and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            level_q      <= 8'h00;
            sample_out_q <= 8'd128;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            sample_out_q <= sample_out_d;
        end
    end

    assign sample_out = sample_out_q;
    assign env_level  = level_q;
    assign active     = (state_q != StIdle);

endmodule

// File: tb/tb_note_envelope.sv
// Scoreboard bench for note_envelope with a short tick period.
module tb_note_envelope;

    localparam int TD   = 4;
    localparam int ASTP = 8;
    localparam int DSTP = 1;
    localparam int SUS  = 160;
    localparam int RSTP = 2;

    localparam int MIdle    = 0;
    localparam int MAttack  = 1;
    localparam int MDecay   = 2;
    localparam int MSustain = 3;
    localparam int MRelease = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sin;
    logic       trig;
    logic       gate_r;
    logic [7:0] sample_out;
    logic [7:0] env_level;
    logic       active;

    int n_checks = 0;
    int n_fails  = 0;

    int m_state;
    int m_lvl;
    int m_cnt;
    logic [7:0] exp_q[$];

    note_envelope #(
        .TICK_DIV     (TD),
        .ATTACK_STEP  (ASTP),
        .DECAY_STEP   (DSTP),
        .SUSTAIN_LEVEL(SUS),
        .RELEASE_STEP (RSTP)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .sample_in (sin),
        .trigger   (trig),
        .gate      (gate_r),
        .sample_out(sample_out),
        .env_level (env_level),
        .active    (active)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = MIdle;
        m_lvl   = 0;
        m_cnt   = 0;
        exp_q.delete();
    endtask

    // Advance the reference envelope by one clock using the currently driven inputs.
    task automatic model_advance();
        bit tk;
        int v;
        tk = (m_cnt == TD - 1);
        if (trig) begin
            m_state = MAttack;
            m_cnt   = 0;
        end else begin
            m_cnt = tk ? 0 : m_cnt + 1;
            if (tk) begin
                case (m_state)
                    MAttack: begin
                        if (!gate_r) m_state = MRelease;
                        else begin
                            v = m_lvl + ASTP;
                            m_lvl = (v > 255) ? 255 : v;
                            if (m_lvl == 255) m_state = MDecay;
                        end
                    end
                    MDecay: begin
                        if (!gate_r) m_state = MRelease;
                        else begin
                            v = m_lvl - DSTP;
                            m_lvl = (v < SUS) ? SUS : v;
                            if (m_lvl == SUS) m_state = MSustain;
                        end
                    end
                    MSustain: begin
                        if (!gate_r) m_state = MRelease;
                    end
                    MRelease: begin
                        v = m_lvl - RSTP;
                        m_lvl = (v < 0) ? 0 : v;
                        if (m_lvl == 0) m_state = MIdle;
                    end
                    default: m_lvl = 0;
                endcase
            end
        end
    endtask

    // One clock: push the expected output, update the model, then compare after the edge.
    task automatic step();
        int s, p, e;
        logic [7:0] ev;
        s  = int'(sin) - 128;
        p  = s * m_lvl;
        e  = 128 + (p >>> 8);
        ev = e[7:0];
        exp_q.push_back(ev);
        model_advance();
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq("sb_empty", 0, 1);
        end else begin
            check_eq("sample_out", sample_out, exp_q.pop_front());
        end
        check_eq("env_level", env_level, m_lvl);
        check_eq("active", active, int'(m_state != MIdle));
        trig = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            sin = 8'($urandom);
            step();
        end
    endtask

    initial begin
        int n;
        bit sc;
        rst    = 1'b1;
        trig   = 1'b0;
        gate_r = 1'b0;
        sin    = 8'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_level", env_level, 0);
        check_eq("rst_out", sample_out, 128);
        check_eq("rst_active", active, 0);
        rst = 1'b0;

        // Idle: output stays midscale whatever the input.
        run(6);
        check_eq("idle_out", sample_out, 128);

        // Attack into decay and sustain.
        trig   = 1'b1;
        gate_r = 1'b1;
        run(1);
        run(4);
        check_eq("atk_tick1", env_level, 8);
        run(4);
        check_eq("atk_tick2", env_level, 16);
        run(120);
        check_eq("atk_peak", env_level, 255);
        sin = 8'd255;
        step();
        check_eq("scale_255_255", sample_out, 254);
        sin = 8'd0;
        step();
        check_eq("scale_255_0", sample_out, 0);
        run(2);
        check_eq("decay_tick33", env_level, 254);
        run(372);
        check_eq("decay_tick126", env_level, 161);
        run(4);
        check_eq("sustain_enter", env_level, 160);
        run(12);
        check_eq("sustain_hold", env_level, 160);

        // Release from sustain: 80 ticks down to idle.
        gate_r = 1'b0;
        run(4);
        check_eq("release_enter", env_level, 160);
        check_eq("release_active", active, 1);
        n = 0;
        while (active && n < 400) begin
            sc  = (m_lvl == 128);
            sin = sc ? 8'd200 : 8'($urandom);
            step();
            n++;
            if (sc) check_eq("scale_128_200", sample_out, 164);
        end
        check_eq("release_cycles", n, 320);
        check_eq("release_level", env_level, 0);
        sin = 8'd77;
        step();
        check_eq("scale_0", sample_out, 128);

        // Retrigger in release at level 100.
        trig   = 1'b1;
        gate_r = 1'b1;
        run(1);
        run(52);
        check_eq("atk_104", env_level, 104);
        gate_r = 1'b0;
        run(12);
        check_eq("rel_100", env_level, 100);
        trig   = 1'b1;
        gate_r = 1'b1;
        run(1);
        check_eq("retrig_keep", env_level, 100);
        check_eq("retrig_active", active, 1);
        run(4);
        check_eq("retrig_108", env_level, 108);

        // Release to idle, then early gate drop during attack at 40.
        gate_r = 1'b0;
        n = 0;
        while (active && n < 1000) begin
            run(1);
            n++;
        end
        check_eq("release_idle", active, 0);
        trig   = 1'b1;
        gate_r = 1'b1;
        run(1);
        run(20);
        check_eq("atk_40", env_level, 40);
        gate_r = 1'b0;
        run(4);
        check_eq("early_rel_40", env_level, 40);
        run(4);
        check_eq("early_rel_38", env_level, 38);

        // Trigger landing on a tick: no release step that cycle.
        run(3);
        trig   = 1'b1;
        gate_r = 1'b1;
        run(1);
        check_eq("trig_on_tick", env_level, 38);
        run(4);
        check_eq("trig_on_tick_46", env_level, 46);

        // Asynchronous reset mid-attack.
        sin = 8'd200;
        run(2);
        #3;
        rst = 1'b1;
        #1;
        check_eq("async_rst_level", env_level, 0);
        check_eq("async_rst_out", sample_out, 128);
        check_eq("async_rst_active", active, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run(8);
        check_eq("post_rst_out", sample_out, 128);
        check_eq("post_rst_active", active, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
